// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: word type, NOP encoding, default fetch step,
// fetch FSM state encoding and a word-alignment helper.
package pipeline_pkg;

  typedef logic [31:0] word_t;

  localparam word_t       NOP_INSTR = 32'h0000_0000;
  localparam int unsigned PC_STEP   = 4;

  // S_REQ : a fetch request is outstanding at the current address
  // S_HOLD: the skid buffer holds a fetched word, no request issued
  // S_DROP: a redirect is pending, the in-flight fetch will be discarded
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

  // Force a byte address onto a word boundary
  function automatic word_t alignWord(input word_t addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a fetched {instruction, pc+step} pair while
// the IF/ID register is stalled.
module fetch_skid_buf
  import pipeline_pkg::*;
(
  input  logic  i_clock,
  input  logic  i_reset,
  input  logic  i_load,
  input  logic  i_unload,
  input  logic  i_clear,
  input  word_t i_instr,
  input  word_t i_pcPlus4,
  output word_t o_instr,
  output word_t o_pcPlus4,
  output logic  o_full
);

  word_t r_instr;
  word_t r_pcPlus4;
  logic  r_full;

  // Capture on load, empty on unload; a clear (redirect) wipes the entry
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_instr   <= NOP_INSTR;
      r_pcPlus4 <= '0;
      r_full    <= 1'b0;
    end else if (i_clear) begin
      r_instr   <= NOP_INSTR;
      r_pcPlus4 <= '0;
      r_full    <= 1'b0;
    end else if (i_load) begin
      r_instr   <= i_instr;
      r_pcPlus4 <= i_pcPlus4;
      r_full    <= 1'b1;
    end else if (i_unload) begin
      r_full    <= 1'b0;
    end
  end

  assign o_instr   = r_instr;
  assign o_pcPlus4 = r_pcPlus4;
  assign o_full    = r_full;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks to instruction memory over a
// req/ack handshake, parks a word in a skid buffer under stall, and flushes
// and redirects on a taken branch from EX.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_branchTaken,
  input  logic [31:0] i_branchTarget,
  output logic        o_iMemReq,
  output logic [31:0] o_iMemAddr,
  input  logic        i_iMemAck,
  input  logic [31:0] i_iMemData,
  output logic [31:0] o_instrOut,
  output logic [31:0] o_pcPlus4Out,
  output logic        o_validOut
);

  import pipeline_pkg::*;

  fetch_state_e r_state;
  fetch_state_e w_nextState;

  word_t r_pc;
  word_t r_dropAddr;
  word_t r_instr;
  word_t r_pcPlus4;
  logic  r_valid;

  word_t w_pcPlusStep;
  word_t w_target;
  logic  w_fetchDone;
  logic  w_skidLoad;
  logic  w_skidUnload;
  logic  w_skidFull;
  word_t w_skidInstr;
  word_t w_skidPcPlus4;

  assign w_pcPlusStep = r_pc + word_t'(PC_STEP);
  assign w_target     = alignWord(i_branchTarget);
  assign w_fetchDone  = (r_state == S_REQ) && i_iMemAck;
  assign w_skidLoad   = w_fetchDone && i_stall && !i_branchTaken;
  assign w_skidUnload = (r_state == S_HOLD) && w_skidFull && !i_stall && !i_branchTaken;

  fetch_skid_buf u_skid (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_load    (w_skidLoad),
    .i_unload  (w_skidUnload),
    .i_clear   (i_branchTaken),
    .i_instr   (i_iMemData),
    .i_pcPlus4 (w_pcPlusStep),
    .o_instr   (w_skidInstr),
    .o_pcPlus4 (w_skidPcPlus4),
    .o_full    (w_skidFull)
  );

  // Fetch FSM state register
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= S_REQ;
    else         r_state <= w_nextState;
  end

  // Next-state logic; a taken branch outranks stall in every state
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_REQ: begin
        if (i_branchTaken)              w_nextState = i_iMemAck ? S_REQ : S_DROP;
        else if (i_iMemAck && i_stall)  w_nextState = S_HOLD;
      end
      S_HOLD: begin
        if (i_branchTaken || !i_stall)  w_nextState = S_REQ;
      end
      S_DROP: begin
        if (i_iMemAck)                  w_nextState = S_REQ;
      end
      default:                          w_nextState = S_REQ;
    endcase
  end

  // Memory-side outputs; the old address is kept on the bus until a dropped fetch is acked
  always_comb begin
    o_iMemReq  = 1'b0;
    o_iMemAddr = r_pc;
    if (!i_reset && (r_state != S_HOLD)) o_iMemReq = 1'b1;
    if (r_state == S_DROP)               o_iMemAddr = r_dropAddr;
  end

  // PC advances on each accepted fetch and jumps to the aligned target on redirect
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)            r_pc <= RESET_PC;
    else if (i_branchTaken) r_pc <= w_target;
    else if (w_fetchDone)   r_pc <= w_pcPlusStep;
  end

  // Remember the address of the fetch that is in flight when a redirect first hits
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)                                                  r_dropAddr <= RESET_PC;
    else if ((r_state == S_REQ) && i_branchTaken && !i_iMemAck)   r_dropAddr <= r_pc;
  end

  // IF/ID register: flush, load from memory or skid, bubble once consumed, hold under stall
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_instr   <= NOP_INSTR;
      r_pcPlus4 <= '0;
      r_valid   <= 1'b0;
    end else if (i_branchTaken) begin
      r_instr   <= NOP_INSTR;
      r_valid   <= 1'b0;
    end else if (w_fetchDone && !i_stall) begin
      r_instr   <= i_iMemData;
      r_pcPlus4 <= w_pcPlusStep;
      r_valid   <= 1'b1;
    end else if (w_skidUnload) begin
      r_instr   <= w_skidInstr;
      r_pcPlus4 <= w_skidPcPlus4;
      r_valid   <= 1'b1;
    end else if (!i_stall) begin
      r_instr   <= NOP_INSTR;
      r_valid   <= 1'b0;
    end
  end

  assign o_instrOut   = r_instr;
  assign o_pcPlus4Out = r_pcPlus4;
  assign o_validOut   = r_valid;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: a behavioural fetch-stream model
// pushes expected IF/ID words into a queue, a monitor pops them whenever the
// decode side consumes a valid instruction.
module tb_if_fetch_stage;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcPlus4;
  } item_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic        iMemReq;
  logic [31:0] iMemAddr;
  logic        iMemAck;
  logic [31:0] iMemData;
  logic [31:0] instrOut;
  logic [31:0] pcPlus4Out;
  logic        validOut;

  int checks = 0;
  int fails  = 0;

  item_t       expQ[$];
  logic [31:0] mPc;
  logic [31:0] mOldAddr;
  logic        mDrop;
  logic        mParked;
  logic        prevBranch;
  int          latency;
  int          waitCnt;

  // Free-running clock
  always #5 clock = ~clock;

  if_fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (4)
  ) dut (
    .i_clock        (clock),
    .i_reset        (reset),
    .i_stall        (stall),
    .i_branchTaken  (branchTaken),
    .i_branchTarget (branchTarget),
    .o_iMemReq      (iMemReq),
    .o_iMemAddr     (iMemAddr),
    .i_iMemAck      (iMemAck),
    .i_iMemData     (iMemData),
    .o_instrOut     (instrOut),
    .o_pcPlus4Out   (pcPlus4Out),
    .o_validOut     (validOut)
  );

  // Memory contents as a pure function of address; address 8 holds 0x8C010004
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'h8C01_000C;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    expQ.delete();
    mPc        = 32'h0;
    mOldAddr   = 32'h0;
    mDrop      = 1'b0;
    mParked    = 1'b0;
    prevBranch = 1'b0;
    waitCnt    = 0;
  endtask

  // One clock of stimulus: drive inputs, play memory, check request side, advance the model
  task automatic applyStimulus(input logic s, input logic b, input logic [31:0] t);
    item_t it;
    logic [31:0] aligned;
    @(negedge clock);
    if (prevBranch) begin
      checkOutput("flushValid", {31'b0, validOut}, 32'h0);
      checkOutput("flushInstr", instrOut, 32'h0);
    end
    stall        = s;
    branchTaken  = b;
    branchTarget = t;
    iMemAck      = 1'b0;
    if (iMemReq) begin
      if (waitCnt >= latency) begin
        iMemAck = 1'b1;
        waitCnt = 0;
      end else begin
        waitCnt++;
      end
    end else begin
      waitCnt = 0;
    end
    iMemData = iMemAck ? memWord(iMemAddr) : $urandom();
    checkOutput("req", {31'b0, iMemReq}, {31'b0, !mParked});
    if (!mParked) checkOutput("addr", iMemAddr, mDrop ? mOldAddr : mPc);
    aligned = {t[31:2], 2'b00};
    if (b) begin
      expQ.delete();
      if (mParked || iMemAck) begin
        mDrop = 1'b0;
      end else if (!mDrop) begin
        mOldAddr = mPc;
        mDrop    = 1'b1;
      end
      mParked = 1'b0;
      mPc     = aligned;
    end else if (mParked) begin
      if (!s) mParked = 1'b0;
    end else if (iMemAck) begin
      if (mDrop) begin
        mDrop = 1'b0;
      end else begin
        it.instr   = memWord(mPc);
        it.pcPlus4 = mPc + 32'd4;
        expQ.push_back(it);
        mPc = mPc + 32'd4;
        if (s) mParked = 1'b1;
      end
    end
    prevBranch = b;
  endtask

  // Monitor: whenever decode consumes a valid IF/ID word, it must be the oldest expected one
  initial begin
    item_t e;
    forever begin
      @(negedge clock);
      #2;
      if (!reset) begin
        if (validOut && !stall && !branchTaken) begin
          if (expQ.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL consume: got pcPlus4 %h expected no valid instruction", pcPlus4Out);
          end else begin
            e = expQ.pop_front();
            checkOutput("instr", instrOut, e.instr);
            checkOutput("pcPlus4", pcPlus4Out, e.pcPlus4);
          end
        end else if (!validOut) begin
          checkOutput("nopInstr", instrOut, 32'h0);
        end
      end
    end
  end

  // Directed scenarios followed by randomized traffic
  initial begin
    logic [31:0] tgt;
    logic        s;
    logic        b;
    reset        = 1'b1;
    stall        = 1'b0;
    branchTaken  = 1'b0;
    branchTarget = 32'h0;
    iMemAck      = 1'b0;
    iMemData     = 32'h0;
    latency      = 0;
    modelReset();
    #12;
    checkOutput("rstReq", {31'b0, iMemReq}, 32'h0);
    checkOutput("rstValid", {31'b0, validOut}, 32'h0);
    checkOutput("rstInstr", instrOut, 32'h0);
    checkOutput("rstPcPlus4", pcPlus4Out, 32'h0);
    checkOutput("rstAddr", iMemAddr, 32'h0);
    @(negedge clock);
    reset = 1'b0;

    // Sequential fetch, then a stall across the ack at address 8
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 32'h0);

    // Branch with same-cycle ack
    applyStimulus(1'b0, 1'b1, 32'h0000_0040);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0);

    // Unaligned target and PC wrap-around
    applyStimulus(1'b0, 1'b1, 32'h0000_0043);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0);

    // Stall and branch together: flush wins
    applyStimulus(1'b1, 1'b1, 32'h0000_0100);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);

    // Slow memory, redirect during the first wait cycle, then a second redirect while dropping
    latency = 3;
    applyStimulus(1'b0, 1'b1, 32'h0000_0080);
    applyStimulus(1'b1, 1'b1, 32'h0000_00C0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 32'h0);

    // Randomized traffic over varying memory latency
    for (int seg = 0; seg < 40; seg++) begin
      latency = $urandom_range(0, 3);
      for (int i = 0; i < 15; i++) begin
        s = ($urandom_range(0, 99) < 25);
        b = ($urandom_range(0, 99) < 6);
        tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
        applyStimulus(s, b, tgt);
      end
    end

    // Asynchronous reset in the middle of a memory wait
    latency = 3;
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    @(posedge clock);
    #3;
    reset       = 1'b1;
    stall       = 1'b0;
    branchTaken = 1'b0;
    iMemAck     = 1'b0;
    #1;
    checkOutput("midRstReq", {31'b0, iMemReq}, 32'h0);
    checkOutput("midRstValid", {31'b0, validOut}, 32'h0);
    checkOutput("midRstInstr", instrOut, 32'h0);
    checkOutput("midRstPcPlus4", pcPlus4Out, 32'h0);
    checkOutput("midRstAddr", iMemAddr, 32'h0);
    modelReset();
    @(negedge clock);
    reset = 1'b0;

    // Drain with fast memory; every fetched word must have been delivered
    latency = 0;
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 32'h0);
    @(negedge clock);
    #3;
    checkOutput("leftover", 32'(expQ.size()), 32'h0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
